// File: rtl/ct_piu_l2cif_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ct_piu_l2cif_rd_ctrl_pkg
// Brief    : Shared encodings for the L2 cache-interface read controller.
// Revision : 1.0 - initial release
// ============================================================================
package ct_piu_l2cif_rd_ctrl_pkg;

    localparam int L2_IDX_W            = 21;
    localparam int L2_WAY_W            = 4;
    localparam int L2_DATA_W           = 128;
    localparam int L2_CNT_W            = 3;
    localparam int L2_SEL_W            = 4;
    localparam int L2_RAM_LAT_DEFAULT  = 3;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t ST_IDLE = 2'd0;
    localparam rd_state_t ST_ARB  = 2'd1;
    localparam rd_state_t ST_WAIT = 2'd2;
    localparam rd_state_t ST_RESP = 2'd3;

    localparam logic [1:0] L2_ARR_TAG      = 2'd0;
    localparam logic [1:0] L2_ARR_TAG_ECC  = 2'd1;
    localparam logic [1:0] L2_ARR_DATA     = 2'd2;
    localparam logic [1:0] L2_ARR_DATA_ECC = 2'd3;

    // Select vector ordering is {data_ecc, data, tag_ecc, tag}.
    function automatic logic sel_is_onehot(input logic [L2_SEL_W-1:0] sel);
        return (sel != '0) && ((sel & (sel - 4'd1)) == '0);
    endfunction

    function automatic logic [1:0] sel_to_code(input logic [L2_SEL_W-1:0] sel);
        logic [1:0] code;
        code = L2_ARR_TAG;
        if (sel[1]) code = L2_ARR_TAG_ECC;
        if (sel[2]) code = L2_ARR_DATA;
        if (sel[3]) code = L2_ARR_DATA_ECC;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ct_piu_l2cif_rd_ctrl_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ct_piu_l2cif_lat_cnt
// Brief    : Loadable 3-bit down-counter timing the L2 RAM read latency.
// Revision : 1.0 - initial release
// ============================================================================
module ct_piu_l2cif_lat_cnt
    import ct_piu_l2cif_rd_ctrl_pkg::*;
(
    input  logic                forever_cpuclk,
    input  logic                cpurst_b,
    input  logic                load,
    input  logic [L2_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic                done
);

    logic [L2_CNT_W-1:0] r_count;

    // Load wins over decrement; the count parks at zero rather than wrapping.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 3'd1;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ct_piu_l2cif_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ct_piu_l2cif_rd_ctrl
// Brief    : Services PIU CSR direct reads of the L2 tag/data arrays.
// Revision : 1.0 - initial release
// ============================================================================
module ct_piu_l2cif_rd_ctrl
    import ct_piu_l2cif_rd_ctrl_pkg::*;
#(
    parameter int RAM_LAT = L2_RAM_LAT_DEFAULT,
    parameter int WAY_NUM = 16
)(
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 piu_l2cif_read_req,
    input  logic                 piu_l2cif_read_tag,
    input  logic                 piu_l2cif_read_tag_ecc,
    input  logic                 piu_l2cif_read_data,
    input  logic                 piu_l2cif_read_data_ecc,
    input  logic [L2_IDX_W-1:0]  piu_l2cif_read_index,
    input  logic [L2_WAY_W-1:0]  piu_l2cif_read_way,
    output logic                 l2cif_piu_read_data_vld,
    output logic [L2_DATA_W-1:0] l2cif_piux_read_data,
    output logic                 l2_rd_arb_req,
    input  logic                 l2_rd_arb_gnt,
    output logic                 l2_rd_en,
    output logic [1:0]           l2_rd_array,
    output logic [L2_IDX_W-1:0]  l2_rd_index,
    output logic [L2_WAY_W-1:0]  l2_rd_way,
    input  logic [L2_DATA_W-1:0] l2_rd_rdata,
    output logic                 l2cif_rd_busy
);

    localparam logic [L2_CNT_W-1:0] LAT_LOAD = L2_CNT_W'(RAM_LAT - 1);

    rd_state_t              r_state;
    rd_state_t              w_state_nxt;
    logic [L2_SEL_W-1:0]    w_sel;
    logic                   w_req_legal;
    logic                   w_accept;
    logic                   w_cnt_done;
    logic                   w_arb_req;
    logic                   w_rd_en;
    logic                   w_vld;
    logic                   w_busy;
    logic [1:0]             r_array;
    logic [L2_IDX_W-1:0]    r_index;
    logic [L2_WAY_W-1:0]    r_way;
    logic [L2_DATA_W-1:0]   r_data;

    assign w_sel = {piu_l2cif_read_data_ecc, piu_l2cif_read_data,
                    piu_l2cif_read_tag_ecc,  piu_l2cif_read_tag};

    assign w_req_legal = sel_is_onehot(w_sel)
                      && ({28'd0, piu_l2cif_read_way} < 32'(WAY_NUM));

    // Requests arriving outside IDLE are dropped; upstream keeps one outstanding.
    assign w_accept = (r_state == ST_IDLE) && piu_l2cif_read_req;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (piu_l2cif_read_req) begin
                    w_state_nxt = w_req_legal ? ST_ARB : ST_RESP;
                end
            end
            ST_ARB: begin
                if (l2_rd_arb_gnt) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_arb_req = 1'b0;
        w_rd_en   = 1'b0;
        w_vld     = 1'b0;
        w_busy    = (r_state != ST_IDLE);
        case (r_state)
            ST_ARB: begin
                w_arb_req = 1'b1;
                w_rd_en   = l2_rd_arb_gnt;
            end
            ST_RESP: begin
                w_vld = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Read address is captured at acceptance so it is stable through rd_en.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_array <= L2_ARR_TAG;
            r_index <= '0;
            r_way   <= '0;
        end else if (w_accept) begin
            r_array <= sel_to_code(w_sel);
            r_index <= piu_l2cif_read_index;
            r_way   <= piu_l2cif_read_way;
        end
    end

    // Illegal requests answer with zero; legal ones return raw RAM data.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_data <= '0;
        end else if (w_accept && !w_req_legal) begin
            r_data <= '0;
        end else if ((r_state == ST_WAIT) && w_cnt_done) begin
            r_data <= l2_rd_rdata;
        end
    end

    ct_piu_l2cif_lat_cnt u_lat_cnt (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .load           (w_rd_en),
        .load_val       (LAT_LOAD),
        .dec            (r_state == ST_WAIT),
        .done           (w_cnt_done)
    );

    assign l2cif_piu_read_data_vld = w_vld;
    assign l2cif_piux_read_data    = r_data;
    assign l2_rd_arb_req           = w_arb_req;
    assign l2_rd_en                = w_rd_en;
    assign l2_rd_array             = r_array;
    assign l2_rd_index             = r_index;
    assign l2_rd_way               = r_way;
    assign l2cif_rd_busy           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_ct_piu_l2cif_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_piu_l2cif_rd_ctrl
// Brief    : Self-checking bench for the L2 cache-interface read controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_piu_l2cif_rd_ctrl;

    localparam int RAM_LAT0 = 3;

    typedef struct {
        logic [3:0]   sel;
        logic [20:0]  index;
        logic [3:0]   way;
        int           gnt_dly;
        logic [127:0] rdata;
        logic         exp_legal;
        logic [1:0]   exp_array;
        int           exp_lat;
        logic [127:0] exp_data;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, req12 = 1'b0, req1 = 1'b0;
    logic gnt0 = 1'b0, gnt12 = 1'b0, gnt1 = 1'b0;
    logic sel_tag = 1'b0, sel_tag_ecc = 1'b0, sel_data = 1'b0, sel_data_ecc = 1'b0;
    logic [20:0]  idx = '0;
    logic [3:0]   way = '0;
    logic [127:0] rdata = '0;

    logic vld0, arb0, en0, busy0;
    logic [127:0] data0;
    logic [1:0] arr0;
    logic [20:0] idx0;
    logic [3:0] way0;
    logic vld12, arb12, en12, busy12;
    logic [127:0] data12;
    logic [1:0] arr12;
    logic [20:0] idx12;
    logic [3:0] way12;
    logic vld1, arb1, en1, busy1;
    logic [127:0] data1;
    logic [1:0] arr1;
    logic [20:0] idx1;
    logic [3:0] way1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic busy_req_ok = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ct_piu_l2cif_rd_ctrl dut0 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .piu_l2cif_read_req(req0),
        .piu_l2cif_read_tag(sel_tag), .piu_l2cif_read_tag_ecc(sel_tag_ecc),
        .piu_l2cif_read_data(sel_data), .piu_l2cif_read_data_ecc(sel_data_ecc),
        .piu_l2cif_read_index(idx), .piu_l2cif_read_way(way),
        .l2cif_piu_read_data_vld(vld0), .l2cif_piux_read_data(data0),
        .l2_rd_arb_req(arb0), .l2_rd_arb_gnt(gnt0), .l2_rd_en(en0),
        .l2_rd_array(arr0), .l2_rd_index(idx0), .l2_rd_way(way0),
        .l2_rd_rdata(rdata), .l2cif_rd_busy(busy0)
    );

    ct_piu_l2cif_rd_ctrl #(.WAY_NUM(12)) dut12 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .piu_l2cif_read_req(req12),
        .piu_l2cif_read_tag(sel_tag), .piu_l2cif_read_tag_ecc(sel_tag_ecc),
        .piu_l2cif_read_data(sel_data), .piu_l2cif_read_data_ecc(sel_data_ecc),
        .piu_l2cif_read_index(idx), .piu_l2cif_read_way(way),
        .l2cif_piu_read_data_vld(vld12), .l2cif_piux_read_data(data12),
        .l2_rd_arb_req(arb12), .l2_rd_arb_gnt(gnt12), .l2_rd_en(en12),
        .l2_rd_array(arr12), .l2_rd_index(idx12), .l2_rd_way(way12),
        .l2_rd_rdata(rdata), .l2cif_rd_busy(busy12)
    );

    ct_piu_l2cif_rd_ctrl #(.RAM_LAT(1)) dut1 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .piu_l2cif_read_req(req1),
        .piu_l2cif_read_tag(sel_tag), .piu_l2cif_read_tag_ecc(sel_tag_ecc),
        .piu_l2cif_read_data(sel_data), .piu_l2cif_read_data_ecc(sel_data_ecc),
        .piu_l2cif_read_index(idx), .piu_l2cif_read_way(way),
        .l2cif_piu_read_data_vld(vld1), .l2cif_piux_read_data(data1),
        .l2_rd_arb_req(arb1), .l2_rd_arb_gnt(gnt1), .l2_rd_en(en1),
        .l2_rd_array(arr1), .l2_rd_index(idx1), .l2_rd_way(way1),
        .l2_rd_rdata(rdata), .l2cif_rd_busy(busy1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_sel(input logic [3:0] s);
        {sel_data_ecc, sel_data, sel_tag_ecc, sel_tag} = s;
    endtask

    task automatic clear_inputs();
        set_sel(4'b0000);
        idx = '0;
        way = '0;
    endtask

    task automatic push_exp(input logic [127:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Scoreboard for dut0: every vld must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (vld0 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld: got vld=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("vld_cycle", 128'(cyc), 128'(e.cyc));
                chk("read_data", data0, e.data);
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL vld_missing: got no vld by cycle %0d, expected at cycle %0d", cyc, e.cyc);
        end
        if (req0 && busy0 && !busy_req_ok) begin
            $display("note: req seen while busy at cycle %0d", cyc);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL vld_timeout: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t0;
        @(negedge clk);
        chk("busy_before_req", busy0, 1'b0);
        req0 = 1'b1;
        set_sel(v.sel);
        idx = v.index;
        way = v.way;
        t0 = cyc;
        push_exp(v.exp_data, t0 + v.exp_lat);
        @(negedge clk);
        req0 = 1'b0;
        clear_inputs();
        chk("busy_after_req", busy0, 1'b1);
        if (v.exp_legal) begin
            for (int d = 0; d < v.gnt_dly; d++) begin
                chk("arb_req_pending", arb0, 1'b1);
                chk("rd_en_no_gnt", en0, 1'b0);
                @(negedge clk);
            end
            gnt0 = 1'b1;
            #1;
            chk("arb_req_at_gnt", arb0, 1'b1);
            chk("rd_en", en0, 1'b1);
            chk("rd_array", arr0, v.exp_array);
            chk("rd_index", idx0, v.index);
            chk("rd_way", way0, v.way);
            @(negedge clk);
            gnt0 = 1'b0;
            for (int k = 1; k <= RAM_LAT0; k++) begin
                chk("arb_req_after_gnt", arb0, 1'b0);
                rdata = (k == RAM_LAT0) ? v.rdata : ~v.rdata;
                @(negedge clk);
            end
            rdata = ~v.rdata;
        end else begin
            chk("arb_req_illegal", arb0, 1'b0);
        end
        drain();
    endtask

    task automatic chk_dut0_zero(input string tag);
        chk({tag, "_vld"}, vld0, 1'b0);
        chk({tag, "_data"}, data0, 128'd0);
        chk({tag, "_arb_req"}, arb0, 1'b0);
        chk({tag, "_rd_en"}, en0, 1'b0);
        chk({tag, "_array"}, arr0, 2'd0);
        chk({tag, "_index"}, idx0, 21'd0);
        chk({tag, "_way"}, way0, 4'd0);
        chk({tag, "_busy"}, busy0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time %0t, expected earlier", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b0100, 21'h1A2B3, 4'd5, 0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
                    1'b1, 2'd2, 5, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
        vecs[1] = '{4'b0001, 21'h00010, 4'd3, 4, 128'h11112222_33334444_55556666_77778888,
                    1'b1, 2'd0, 9, 128'h11112222_33334444_55556666_77778888};
        vecs[2] = '{4'b0010, 21'h1FFFFF, 4'd0, 1, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0,
                    1'b1, 2'd1, 6, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0};
        vecs[3] = '{4'b1000, 21'h00000, 4'd15, 2, 128'h00000000_00000000_00000000_00000001,
                    1'b1, 2'd3, 7, 128'h00000000_00000000_00000000_00000001};
        vecs[4] = '{4'b0101, 21'h00005, 4'd2, 0, 128'hFFFF, 1'b0, 2'd0, 1, 128'd0};
        vecs[5] = '{4'b0000, 21'h00123, 4'd1, 0, 128'hFFFF, 1'b0, 2'd0, 1, 128'd0};
        vecs[6] = '{4'b1100, 21'h0BEEF, 4'd0, 0, 128'hFFFF, 1'b0, 2'd0, 1, 128'd0};

        repeat (3) @(negedge clk);
        chk_dut0_zero("reset");
        chk("reset_w12_busy", busy12, 1'b0);
        chk("reset_l1_vld", vld1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_dut0_zero("post_reset");

        // Grant without a pending request must do nothing.
        gnt0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_gnt_rd_en", en0, 1'b0);
            chk("idle_gnt_busy", busy0, 1'b0);
        end
        gnt0 = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Second request while the first is in WAIT is ignored.
        begin
            int t0;
            logic [127:0] d2;
            d2 = 128'h0BADC0DE_12345678_9ABCDEF0_FEEDFACE;
            @(negedge clk);
            req0 = 1'b1; set_sel(4'b0100); idx = 21'h0ABCD; way = 4'd9;
            t0 = cyc;
            push_exp(d2, t0 + 5);
            @(negedge clk);
            req0 = 1'b0; clear_inputs(); gnt0 = 1'b1; rdata = ~d2;
            chk("b2b_busy_arb", busy0, 1'b1);
            @(negedge clk);
            gnt0 = 1'b0; busy_req_ok = 1'b1; req0 = 1'b1; set_sel(4'b0001);
            idx = 21'h00001; way = 4'd1;
            chk("b2b_busy_wait1", busy0, 1'b1);
            @(negedge clk);
            req0 = 1'b0; busy_req_ok = 1'b0; clear_inputs();
            chk("b2b_busy_wait2", busy0, 1'b1);
            chk("b2b_index_held", idx0, 21'h0ABCD);
            chk("b2b_no_arb", arb0, 1'b0);
            @(negedge clk);
            rdata = d2;
            chk("b2b_busy_wait3", busy0, 1'b1);
            @(negedge clk);
            rdata = ~d2;
            chk("b2b_busy_resp", busy0, 1'b1);
            drain();
            repeat (4) @(negedge clk);
            chk("b2b_idle_after", busy0, 1'b0);
            chk("b2b_data_held", data0, d2);
        end

        // Reset during WAIT: everything clears and no response appears.
        @(negedge clk);
        req0 = 1'b1; set_sel(4'b0100); idx = 21'h15555; way = 4'd7;
        @(negedge clk);
        req0 = 1'b0; clear_inputs(); gnt0 = 1'b1;
        #1;
        chk("rst_seq_rd_en", en0, 1'b1);
        @(negedge clk);
        gnt0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_dut0_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rdata = 128'h77;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after_reset_vld", vld0, 1'b0);
            chk("after_reset_busy", busy0, 1'b0);
        end
        run_vec(vecs[2]);

        // WAY_NUM=12 build: legal way 11, then illegal way 15.
        @(negedge clk);
        req12 = 1'b1; set_sel(4'b0010); idx = 21'h00777; way = 4'd11;
        @(negedge clk);
        req12 = 1'b0; clear_inputs();
        chk("w12_arb_req", arb12, 1'b1);
        gnt12 = 1'b1;
        #1;
        chk("w12_rd_en", en12, 1'b1);
        chk("w12_array", arr12, 2'd1);
        chk("w12_way", way12, 4'd11);
        @(negedge clk);
        gnt12 = 1'b0; rdata = 128'h0;
        @(negedge clk);
        @(negedge clk);
        rdata = 128'h12345;
        @(negedge clk);
        rdata = 128'h0;
        chk("w12_vld", vld12, 1'b1);
        chk("w12_data", data12, 128'h12345);
        @(negedge clk);
        req12 = 1'b1; set_sel(4'b0100); idx = 21'h00042; way = 4'd15;
        @(negedge clk);
        req12 = 1'b0; clear_inputs();
        chk("w12_illegal_vld", vld12, 1'b1);
        chk("w12_illegal_data", data12, 128'd0);
        chk("w12_illegal_arb", arb12, 1'b0);
        @(negedge clk);
        chk("w12_illegal_vld_once", vld12, 1'b0);
        chk("w12_illegal_idle", busy12, 1'b0);
        chk("w12_illegal_arb2", arb12, 1'b0);

        // RAM_LAT=1 build with immediate grant: vld three cycles after req.
        @(negedge clk);
        req1 = 1'b1; set_sel(4'b1000); idx = 21'h00321; way = 4'd3;
        @(negedge clk);
        req1 = 1'b0; clear_inputs(); gnt1 = 1'b1;
        #1;
        chk("l1_rd_en", en1, 1'b1);
        chk("l1_array", arr1, 2'd3);
        @(negedge clk);
        gnt1 = 1'b0; rdata = 128'hCAFE_0001;
        chk("l1_vld_early", vld1, 1'b0);
        @(negedge clk);
        rdata = 128'h0;
        chk("l1_vld", vld1, 1'b1);
        chk("l1_data", data1, 128'hCAFE_0001);
        @(negedge clk);
        chk("l1_vld_once", vld1, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
